e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit controller, sitting beside the E-stage ALU.
- Accepts mult/multu/div/divu issue requests and sequences a fixed-latency busy window; the latency differs for multiply and divide.
- Owns the architectural HI/LO registers and services mfhi/mflo/mthi/mtlo.
- Exposes busy so the hazard unit can stall later MD-class instructions in D.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  E-stage instruction is MD-class; qualifies MDUOp
MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
req  input  1  exception/interrupt taken this cycle; suppresses state changes by the E-stage instruction
busy  output  1  multi-cycle operation in flight
HI  output  32  architectural HI
LO  output  32  architectural LO
MDOut  output  32  read data for mfhi/mflo

Behaviour:
- Reset (reset low, asynchronous) forces:
  - busy=0, HI=0, LO=0, internal counter=0.
  - Any pending result is discarded.
  - These values take effect immediately, including mid-operation.
- Issue condition: start=1, MDUOp in {1..4}, busy=0 and req=0 at rising edge t.
  - At edge t, A and B are captured and the 64-bit result is computed into a pending register.
  - The counter loads MULT_CYCLES or DIV_CYCLES. busy=1 after edge t.
- Counting:
  - Each edge while busy decrements the counter.
  - On the edge where the counter goes 1->0, {HI,LO} take the pending result and busy drops.
  - Result: busy is high for exactly N cycles, and new HI/LO are visible in the same cycle busy first reads 0.
- Issue while busy: ignored; the in-flight op is unaffected. The hazard unit is responsible for preventing this.
- req=1:
  - Blocks issue and MTHI/MTLO that cycle.
  - Does not abort an in-flight operation; the operation completes normally.
- Arithmetic:
  - MULT: signed 32x32->64, {HI,LO}=product.
  - MULTU: unsigned 32x32->64, {HI,LO}=product.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - B=0 on DIV/DIVU: busy sequence runs normally; HI and LO keep their prior values at completion.
- MTHI/MTLO:
  - Condition: start=1, busy=0, req=0. HI or LO <= A at the edge; no busy window.
  - While busy: the write is ignored.
- MFHI/MFLO: MDOut is combinational; MDUOp=5 gives HI, 6 gives LO, any other value gives 0. No start qualification.
- During busy, MDOut returns the old HI/LO values.
- Counter width is 4 bits; no wrap beyond the loaded value.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=5, start one cycle:
  - busy high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU, A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV by zero after MTHI A=0x1234 and MTLO A=0x5678:
  - busy 10 cycles.
  - Then HI=0x1234, LO=0x5678.
  - MFHI gives MDOut=0x1234.
- Ignored and suppressed ops:
  - Issue MULT, then on busy cycle 2 assert start with DIVU and MTLO A=0xAAAA: both ignored; the MULT result lands after cycle 5.
  - Separately, start MULT with req=1: busy stays 0 and HI/LO are unchanged.
- Reset mid-operation:
  - Issue DIV, then pull reset low asynchronously mid-cycle at busy cycle 4.
  - busy, HI and LO read 0 immediately.
  - After release, no late HI/LO update occurs.

Source files
------------

// File: rtl/e_mdu.sv
// E-stage multiply/divide controller: sequences a fixed-latency busy window per op
// and owns the architectural HI/LO pair, committing results when the window closes.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    localparam logic [3:0] MultLat = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLat  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Arithmetic datapath, evaluated every cycle and captured only on issue.
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, div_bs, div_bu;
    logic [31:0] q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;
    logic        b_zero;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    assign b_zero = (B == 32'd0);
    assign a_mag  = A[31] ? (~A + 32'd1) : A;
    assign b_mag  = B[31] ? (~B + 32'd1) : B;
    // Divide-by-zero results are never committed; the substitute divisor only keeps X out.
    assign div_bs = b_zero ? 32'd1 : b_mag;
    assign div_bu = b_zero ? 32'd1 : B;

    // Magnitude division makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
    assign q_mag  = a_mag / div_bs;
    assign r_mag  = a_mag % div_bs;
    assign quot_s = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s  = A[31] ? (~r_mag + 32'd1) : r_mag;
    assign quot_u = A / div_bu;
    assign rem_u  = A % div_bu;

    logic can_act;
    assign can_act = start && (state_q == StIdle) && !req;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (can_act) begin
                    case (MDUOp)
                        OpMult: begin
                            pend_d    = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = MultLat;
                            state_d   = StBusy;
                        end
                        OpMultu: begin
                            pend_d    = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = MultLat;
                            state_d   = StBusy;
                        end
                        OpDiv: begin
                            pend_d    = {rem_s, quot_s};
                            pend_wr_d = !b_zero;
                            cnt_d     = DivLat;
                            state_d   = StBusy;
                        end
                        OpDivu: begin
                            pend_d    = {rem_u, quot_u};
                            pend_wr_d = !b_zero;
                            cnt_d     = DivLat;
                            state_d   = StBusy;
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                // <= 1 rather than == 1 so a zero load can never wrap the counter.
                if (cnt_q <= 4'd1) begin
                    cnt_d     = 4'd0;
                    state_d   = StIdle;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        MDOut = 32'd0;
        case (MDUOp)
            OpMfhi:  MDOut = hi_q;
            OpMflo:  MDOut = lo_q;
            default: ;
        endcase
    end

    assign busy = (state_q == StBusy);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected completions, a negedge monitor
// measures each busy window and checks HI/LO when busy drops.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        req = 1'b0;
    logic        busy;
    logic [31:0] HI, LO, MDOut;

    e_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .MDUOp(MDUOp),
        .A    (A),
        .B    (B),
        .req  (req),
        .busy (busy),
        .HI   (HI),
        .LO   (LO),
        .MDOut(MDOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles at negedge, checks the queued result when busy falls.
    bit   mon_prev = 1'b0;
    int   mon_cnt = 0;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_prev = 1'b0;
                mon_cnt  = 0;
            end else if (busy) begin
                mon_cnt++;
                mon_prev = 1'b1;
            end else begin
                if (mon_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=HI %h LO %h required=no completion",
                                 HI, LO);
                    end else begin
                        mon_e = sb.pop_front();
                        chk({mon_e.name, "_cycles"}, 32'(mon_cnt), 32'(mon_e.cycles));
                        chk({mon_e.name, "_hi"}, HI, mon_e.hi);
                        chk({mon_e.name, "_lo"}, LO, mon_e.lo);
                    end
                end
                mon_prev = 1'b0;
                mon_cnt  = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic r);
        start = s;
        MDUOp = op;
        A     = a;
        B     = b;
        req   = r;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int cyc,
                         input string name);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.cycles = cyc;
        e.name = name;
        sb.push_back(e);
        drive(1'b1, op, a, b, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        issue(4'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, "mult");
        wait_idle("mult");

        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, "multu");
        MDUOp = 4'd5;
        #1 chk("mfhi_during_busy", MDOut, 32'hFFFF_FFFF);
        wait_idle("multu");
        chk("mfhi_after_multu", MDOut, 32'h0000_0001);
        MDUOp = 4'd0;

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div");
        wait_idle("div");

        drive(1'b1, 4'd7, 32'h1234, 32'd0, 1'b0);
        tick();
        drive(1'b1, 4'd8, 32'h5678, 32'd0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("mthi", HI, 32'h1234);
        chk("mtlo", LO, 32'h5678);
        issue(4'd3, 32'd99, 32'd0, 32'h1234, 32'h5678, 10, "div_by_zero");
        wait_idle("div_by_zero");
        MDUOp = 4'd5;
        #1 chk("mfhi", MDOut, 32'h1234);
        MDUOp = 4'd6;
        #1 chk("mflo", MDOut, 32'h5678);
        MDUOp = 4'd9;
        #1 chk("mdout_other", MDOut, 32'd0);
        MDUOp = 4'd0;

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, "div_ovf");
        wait_idle("div_ovf");

        issue(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, "divu");
        wait_idle("divu");

        // DIVU and MTLO presented while busy must both be dropped.
        issue(4'd1, 32'd6, 32'd7, 32'd0, 32'h2A, 5, "mult_ignore");
        tick();
        drive(1'b1, 4'd4, 32'd100, 32'd3, 1'b0);
        tick();
        drive(1'b1, 4'd8, 32'hAAAA, 32'd0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("mtlo_while_busy", LO, 32'd14);
        wait_idle("mult_ignore");

        drive(1'b1, 4'd1, 32'd3, 32'd3, 1'b1);
        tick();
        chk("req_busy", {31'd0, busy}, 32'd0);
        chk("req_hi", HI, 32'd0);
        chk("req_lo", LO, 32'h2A);
        drive(1'b1, 4'd7, 32'hBEEF, 32'd0, 1'b1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("req_mthi", HI, 32'd0);

        drive(1'b1, 4'd7, 32'h55, 32'd0, 1'b0);
        tick();
        drive(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        chk("midop_rst_busy", {31'd0, busy}, 32'd0);
        chk("midop_rst_hi", HI, 32'd0);
        chk("midop_rst_lo", LO, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (15) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_hi", HI, 32'd0);
        chk("post_rst_lo", LO, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
